// File: rtl/sm_fetch_queue_if.sv
// Bus bundle between sm_fetch_queue, the CPU fetch port (imAddr/imData)
// and the slow instruction memory (memReq/memAck). The queue is the slave
// side; the master side is whatever drives the CPU and memory inputs.
interface sm_fetch_queue_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imAddr;
  logic              imTake;
  logic [31:0]       imData;
  logic              imValid;
  logic              memReq;
  logic [ADDR_W-1:0] memAddr;
  logic              memAck;
  logic [31:0]       memData;

  modport master (
    output imAddr, imTake, memAck, memData,
    input  imData, imValid, memReq, memAddr
  );

  modport slave (
    input  imAddr, imTake, memAck, memData,
    output imData, imValid, memReq, memAddr
  );
endinterface

// File: rtl/sm_fetch_queue.sv
// Instruction prefetch queue. Fetches sequential words ahead of the CPU pc
// into a small FIFO and presents the head word combinationally. A pc that
// does not match the expected head address is treated as a redirect: the
// queue is flushed and fetching restarts at the new pc. At most one memory
// request is ever outstanding, and one is only issued while there is room,
// so an acknowledged word always fits.
module sm_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic            clk,
  input logic            rst,
  sm_fetch_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // DISCARD waits out a request whose address went stale after a redirect.
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t            state, state_next;
  logic [31:0]       queue [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [ADDR_W-1:0] head_addr, head_addr_next;
  logic [ADDR_W-1:0] fetch_addr, fetch_addr_next;
  logic              mem_req, mem_req_next;
  logic [ADDR_W-1:0] mem_addr, mem_addr_next;
  logic              miss, im_valid, pop, push, flush;

  // Redirect detection: compare the pc against the head word when the queue
  // holds data, otherwise against the address the next fetch will use.
  always_comb begin
    miss = 1'b0;
    if (count != '0) miss = (bus.imAddr != head_addr);
    else             miss = (bus.imAddr != fetch_addr);
  end

  assign im_valid    = (count != '0) && (head_addr == bus.imAddr);
  assign pop         = bus.imTake && im_valid && !miss;
  assign bus.imValid = im_valid;
  assign bus.imData  = queue[rd_ptr];
  assign bus.memReq  = mem_req;
  assign bus.memAddr = mem_addr;

  // Next-state and datapath updates; a flush overrides any pop bookkeeping
  // and retargets both the head and the fetch address to the new pc.
  always_comb begin
    state_next      = state;
    count_next      = count;
    head_addr_next  = head_addr;
    fetch_addr_next = fetch_addr;
    mem_addr_next   = mem_addr;
    mem_req_next    = 1'b0;
    push            = 1'b0;
    flush           = 1'b0;

    if (pop) begin
      head_addr_next = head_addr + 1'b1;
      count_next     = count - 1'b1;
    end

    case (state)
      IDLE: begin
        if (miss) begin
          flush      = 1'b1;
          state_next = FETCH;
        end else if (count_next < FULL) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (miss) begin
          flush = 1'b1;
          if (!bus.memAck) state_next = DISCARD;
        end else if (bus.memAck) begin
          push            = 1'b1;
          fetch_addr_next = fetch_addr + 1'b1;
          count_next      = count_next + 1'b1;
          if (count_next == FULL) state_next = IDLE;
        end
      end
      DISCARD: begin
        if (miss) flush = 1'b1;
        if (bus.memAck) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      count_next      = '0;
      head_addr_next  = bus.imAddr;
      fetch_addr_next = bus.imAddr;
    end

    mem_req_next = (state_next != IDLE);
    if ((state_next == FETCH && state != FETCH) || (state == FETCH && bus.memAck))
      mem_addr_next = fetch_addr_next;
  end

  // State, pointers, addresses and the registered memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      head_addr  <= head_addr_next;
      fetch_addr <= fetch_addr_next;
      mem_req    <= mem_req_next;
      mem_addr   <= mem_addr_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  // Queue storage; data words need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (!rst && push) queue[wr_ptr] <= bus.memData;
  end

endmodule

// File: tb/tb_sm_fetch_queue.sv
// Directed bench for sm_fetch_queue: a cycle-stepped CPU and memory model
// around the queue, with hand-computed expectations for each scenario.
module tb_sm_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sm_fetch_queue_if #(.ADDR_W(32)) bus ();

  sm_fetch_queue #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int memMode = 0;
  int ackDelay = 0;
  int waitCnt = 0;
  int ackCount = 0;
  bit cpuAuto = 1'b0;
  bit took = 1'b0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then step the memory and CPU models for the new cycle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    if (cpuAuto && took) bus.imAddr = bus.imAddr + 32'd1;
    if (memMode != 0 && bus.memReq) begin
      if (waitCnt >= ackDelay) begin
        bus.memAck  = 1'b1;
        bus.memData = 32'hA5A50000 | bus.memAddr;
        ackCount++;
        waitCnt = 0;
      end else begin
        bus.memAck = 1'b0;
        waitCnt++;
      end
    end else begin
      bus.memAck = 1'b0;
      waitCnt = 0;
    end
    #1;
    if (cpuAuto) bus.imTake = bus.imValid;
    #1;
    took = bus.imTake && bus.imValid;
  endtask

  // Two reset cycles; on return the DUT sits in its reset state, rst low.
  task automatic doReset();
    rst = 1'b1;
    bus.imAddr = '0;
    bus.imTake = 1'b0;
    bus.memAck = 1'b0;
    bus.memData = '0;
    memMode = 0;
    ackDelay = 0;
    cpuAuto = 1'b0;
    took = 1'b0;
    ackCount = 0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    #1;
  endtask

  // Scenario sequence.
  initial begin
    // Reset state and streaming with zero-wait memory
    doReset();
    checkOutput("rst_memReq", 32'(bus.memReq), 32'd0);
    checkOutput("rst_memAddr", bus.memAddr, 32'd0);
    checkOutput("rst_imValid", 32'(bus.imValid), 32'd0);
    checkOutput("rst_count", 32'(dut.count), 32'd0);
    memMode = 1;
    cpuAuto = 1'b1;
    applyStimulus();
    checkOutput("s1_c1_memReq", 32'(bus.memReq), 32'd1);
    checkOutput("s1_c1_memAddr", bus.memAddr, 32'd0);
    checkOutput("s1_c1_imValid", 32'(bus.imValid), 32'd0);
    applyStimulus();
    checkOutput("s1_c2_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s1_c2_imData", bus.imData, 32'hA5A50000);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus();
      checkOutput("s1_stream_addr", bus.imAddr, 32'(k));
      checkOutput("s1_stream_valid", 32'(bus.imValid), 32'd1);
      checkOutput("s1_stream_data", bus.imData, 32'hA5A50000 | 32'(k));
    end

    // Fill without consuming, then one take restarts fetching
    doReset();
    memMode = 1;
    for (int k = 0; k < 6; k++) applyStimulus();
    checkOutput("s2_acks", 32'(ackCount), 32'd4);
    checkOutput("s2_memReq_full", 32'(bus.memReq), 32'd0);
    checkOutput("s2_count_full", 32'(dut.count), 32'd4);
    checkOutput("s2_head_data", bus.imData, 32'hA5A50000);
    bus.imTake = 1'b1;
    applyStimulus();
    bus.imTake = 1'b0;
    bus.imAddr = 32'd1;
    #1;
    checkOutput("s2_memReq_after_take", 32'(bus.memReq), 32'd1);
    checkOutput("s2_memAddr_after_take", bus.memAddr, 32'd4);
    checkOutput("s2_next_data", bus.imData, 32'hA5A50001);

    // Redirect while a slow request is pending
    doReset();
    memMode = 1;
    ackDelay = 3;
    bus.imAddr = 32'h13;
    applyStimulus();
    checkOutput("s3_c1_memAddr", bus.memAddr, 32'h13);
    bus.imAddr = 32'h40;
    applyStimulus();
    checkOutput("s3_c2_memAddr", bus.memAddr, 32'h13);
    applyStimulus();
    checkOutput("s3_c3_memAddr", bus.memAddr, 32'h13);
    applyStimulus();
    checkOutput("s3_c4_memAck", 32'(bus.memAck), 32'd1);
    checkOutput("s3_c4_memAddr", bus.memAddr, 32'h13);
    for (int k = 5; k <= 8; k++) begin
      applyStimulus();
      checkOutput("s3_wait_memAddr", bus.memAddr, 32'h40);
      checkOutput("s3_wait_imValid", 32'(bus.imValid), 32'd0);
    end
    checkOutput("s3_dropped_count", 32'(dut.count), 32'd0);
    applyStimulus();
    checkOutput("s3_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s3_imData", bus.imData, 32'hA5A50040);

    // Redirect in the same cycle as an ack
    doReset();
    memMode = 1;
    bus.imAddr = 32'h05;
    applyStimulus();
    checkOutput("s4_c1_memAddr", bus.memAddr, 32'h05);
    checkOutput("s4_c1_memAck", 32'(bus.memAck), 32'd1);
    bus.imAddr = 32'h80;
    applyStimulus();
    checkOutput("s4_c2_memAddr", bus.memAddr, 32'h80);
    checkOutput("s4_c2_count", 32'(dut.count), 32'd0);
    checkOutput("s4_c2_imValid", 32'(bus.imValid), 32'd0);
    applyStimulus();
    checkOutput("s4_c3_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s4_c3_imData", bus.imData, 32'hA5A50080);

    // Address wrap from all-ones to zero
    doReset();
    memMode = 1;
    cpuAuto = 1'b1;
    bus.imAddr = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("s5_c1_memAddr", bus.memAddr, 32'hFFFFFFFF);
    applyStimulus();
    checkOutput("s5_c2_memAddr", bus.memAddr, 32'h00000000);
    checkOutput("s5_c2_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s5_c2_imData", bus.imData, 32'hFFFFFFFF);
    applyStimulus();
    checkOutput("s5_c3_memAddr", bus.memAddr, 32'h00000001);
    checkOutput("s5_c3_imAddr", bus.imAddr, 32'h00000000);
    checkOutput("s5_c3_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s5_c3_imData", bus.imData, 32'hA5A50000);
    applyStimulus();
    checkOutput("s5_c4_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s5_c4_imData", bus.imData, 32'hA5A50001);

    // Reset during an outstanding request, then a late ack
    doReset();
    applyStimulus();
    checkOutput("s6_pending_memReq", 32'(bus.memReq), 32'd1);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("s6_after_rst_memReq", 32'(bus.memReq), 32'd0);
    checkOutput("s6_after_rst_imValid", 32'(bus.imValid), 32'd0);
    bus.memAck = 1'b1;
    bus.memData = 32'hDEADBEEF;
    #1;
    applyStimulus();
    checkOutput("s6_late_ack_count", 32'(dut.count), 32'd0);
    checkOutput("s6_refetch_memReq", 32'(bus.memReq), 32'd1);
    checkOutput("s6_refetch_memAddr", bus.memAddr, 32'd0);
    checkOutput("s6_refetch_imValid", 32'(bus.imValid), 32'd0);
    memMode = 1;
    applyStimulus();
    checkOutput("s6_ack_memAck", 32'(bus.memAck), 32'd1);
    applyStimulus();
    checkOutput("s6_imValid", 32'(bus.imValid), 32'd1);
    checkOutput("s6_imData", bus.imData, 32'hA5A50000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
